// File: rtl/vedic_pp_stage_16_if.sv
// Operand/product handshake bundle for the Vedic partial-product stage.
// The slave modport is the stage itself; the master modport is whoever feeds and drains it.
interface vedic_pp_stage_16_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      csa_a;
  logic [15:0]      csa_b;
  logic [15:0]      csa_c;
  logic [7:0]       p_lo;
  logic [15:0]      p_hh;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, csa_a, csa_b, csa_c, p_lo, p_hh, op_count
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, csa_a, csa_b, csa_c, p_lo, p_hh, op_count
  );
endinterface

// File: rtl/vedic_pp_stage_16.sv
// Two-stage feeder for the 16x16 Vedic multiplier's carry-save stage: S1 registers
// the operands, S2 registers the four 8x8 vertical/crosswise products.
module vedic_pp_stage_16 #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  vedic_pp_stage_16_if.slave     bus
);

  // Urdhva-tiryagbhyam 2x2 kernel: vertical, crosswise, vertical.
  function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
    logic pp0, pp1, pp2, pp3, c;
    pp0 = a[0] & b[0];
    pp1 = a[1] & b[0];
    pp2 = a[0] & b[1];
    pp3 = a[1] & b[1];
    c   = pp1 & pp2;
    return {pp3 & c, pp3 ^ c, pp1 ^ pp2, pp0};
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] mid;
    q0  = vm2(a[1:0], b[1:0]);
    q1  = vm2(a[3:2], b[1:0]);
    q2  = vm2(a[1:0], b[3:2]);
    q3  = vm2(a[3:2], b[3:2]);
    mid = {2'b00, q1} + {2'b00, q2};
    return {4'b0000, q0} + {mid, 2'b00} + {q3, 4'b0000};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q0, q1, q2, q3;
    logic [9:0] mid;
    q0  = vm4(a[3:0], b[3:0]);
    q1  = vm4(a[7:4], b[3:0]);
    q2  = vm4(a[3:0], b[7:4]);
    q3  = vm4(a[7:4], b[7:4]);
    mid = {2'b00, q1} + {2'b00, q2};
    return {8'h00, q0} + {2'b00, mid, 4'h0} + {q3, 8'h00};
  endfunction

  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic             r_v1;
  logic [15:0]      r_q0;
  logic [15:0]      r_q1;
  logic [15:0]      r_q2;
  logic [15:0]      r_q3;
  logic             r_v2;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_accept;
  logic [15:0]      w_q0;
  logic [15:0]      w_q1;
  logic [15:0]      w_q2;
  logic [15:0]      w_q3;

  // An empty S2 always loads, so a bubble there never stalls S1.
  assign w_s2_load  = !r_v2 || bus.out_ready;
  assign w_in_ready = !r_v1 || w_s2_load;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_q0 = vm8(r_a[7:0],  r_b[7:0]);
  assign w_q1 = vm8(r_a[15:8], r_b[7:0]);
  assign w_q2 = vm8(r_a[7:0],  r_b[15:8]);
  assign w_q3 = vm8(r_a[15:8], r_b[15:8]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_v1       <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_a        <= bus.in_a;
        r_b        <= bus.in_b;
        r_v1       <= 1'b1;
        r_op_count <= r_op_count + 1'b1;
      end else if (w_s2_load) begin
        r_v1 <= 1'b0;
      end
    end
  end

  // Product registers only move when S1 actually holds an operation, so operand
  // garbage seen while idle never reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q0 <= '0;
      r_q1 <= '0;
      r_q2 <= '0;
      r_q3 <= '0;
      r_v2 <= 1'b0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_q0 <= w_q0;
        r_q1 <= w_q1;
        r_q2 <= w_q2;
        r_q3 <= w_q3;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v2;
  assign bus.csa_a     = r_q1;
  assign bus.csa_b     = r_q2;
  assign bus.csa_c     = {8'h00, r_q0[15:8]};
  assign bus.p_lo      = r_q0[7:0];
  assign bus.p_hh      = r_q3;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_vedic_pp_stage_16.sv
// Scoreboard bench for vedic_pp_stage_16: accepts push an arithmetic reference,
// a negedge monitor pops on every output transfer and checks hold-while-stalled.
module tb_vedic_pp_stage_16;

  logic clk;
  logic rst;

  vedic_pp_stage_16_if #(.CNT_W(16)) bus();

  vedic_pp_stage_16 #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  op_t         sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fire   = 0;
  logic [15:0] model_cnt = '0;
  logic        prev_stall = 1'b0;
  logic [71:0] prev_out;
  logic        rand_ready = 1'b0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [71:0] out_vec();
    return {bus.csa_a, bus.csa_b, bus.csa_c, bus.p_lo, bus.p_hh};
  endfunction

  function automatic logic [31:0] recon();
    logic [31:0] s;
    s = {bus.p_hh, 16'h0000}
      + (({16'h0, bus.csa_a} + {16'h0, bus.csa_b} + {16'h0, bus.csa_c}) << 8)
      + {24'h0, bus.p_lo};
    return s;
  endfunction

  // Reference: split operands and multiply the halves with plain arithmetic.
  function automatic logic [71:0] ref_vec(input op_t op);
    logic [15:0] q0, q1, q2, q3;
    q0 = {8'h00, op.a[7:0]}  * {8'h00, op.b[7:0]};
    q1 = {8'h00, op.a[15:8]} * {8'h00, op.b[7:0]};
    q2 = {8'h00, op.a[7:0]}  * {8'h00, op.b[15:8]};
    q3 = {8'h00, op.a[15:8]} * {8'h00, op.b[15:8]};
    return {q1, q2, {8'h00, q0[15:8]}, q0[7:0], q3};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_cnt  = '0;
      prev_stall = 1'b0;
    end else begin
      check("op_count", {56'h0, bus.op_count}, {56'h0, model_cnt});
      if (prev_stall) begin
        check("stall_valid_hold", {71'h0, bus.out_valid}, 72'h1);
        check("stall_data_hold", out_vec(), prev_out);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_fire++;
        if (sb.size() == 0) begin
          check("unexpected_output", out_vec(), 72'h0);
          n_checks++;
          $display("FAIL unexpected_output: output with empty scoreboard");
        end else begin
          op_t e;
          e = sb.pop_front();
          check("fields", out_vec(), ref_vec(e));
          check("product", {40'h0, recon()}, {40'h0, {16'h0, e.a} * {16'h0, e.b}});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{a: bus.in_a, b: bus.in_b});
        model_cnt = model_cnt + 16'd1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = out_vec();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) check("send_timeout", 72'h0, 72'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = 16'($urandom);
    bus.in_b = 16'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_empty", {40'h0, 32'(sb.size())}, 72'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 16'($urandom);
    bus.in_b = 16'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_out_valid", {71'h0, bus.out_valid}, 72'h0);
    check("rst_in_ready", {71'h0, bus.in_ready}, 72'h1);
    check("rst_op_count", {56'h0, bus.op_count}, 72'h0);
    check("rst_outputs", out_vec(), 72'h0);
  endtask

  initial begin
    int w;
    int tot;
    int fires0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed: basic operand pair, latency 2
    bus.out_ready = 1'b1;
    send(16'h1234, 16'h5678, w);
    check("lat_not_yet", {71'h0, bus.out_valid}, 72'h0);
    @(posedge clk);
    #1;
    check("lat_valid", {71'h0, bus.out_valid}, 72'h1);
    check("basic_fields", out_vec(), {16'h0870, 16'h1178, 16'h0018, 8'h60, 16'h060C});
    check("basic_product", {40'h0, recon()}, {40'h0, 32'h06260060});

    send(16'hFFFF, 16'hFFFF, w);
    @(posedge clk);
    #1;
    check("max_fields", out_vec(), {16'hFE01, 16'hFE01, 16'h00FE, 8'h01, 16'hFE01});
    check("max_product", {40'h0, recon()}, {40'h0, 32'hFFFE0001});
    drain();

    // Backpressure: two accepts fill both stages
    do_reset();
    bus.out_ready = 1'b0;
    tot = 0;
    send(16'($urandom), 16'($urandom), w); tot += w;
    send(16'($urandom), 16'($urandom), w); tot += w;
    check("bp_two_accepts_free", {40'h0, 32'(tot)}, 72'h0);
    check("bp_in_ready_low", {71'h0, bus.in_ready}, 72'h0);
    bus.in_valid = 1'b1;
    bus.in_a = 16'hA5C3;
    bus.in_b = 16'h3C5A;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("bp_still_blocked", {71'h0, bus.in_ready}, 72'h0);
    bus.out_ready = 1'b1;
    send(16'hA5C3, 16'h3C5A, w);
    send(16'($urandom), 16'($urandom), w);
    drain();
    check("bp_op_count", {56'h0, bus.op_count}, 72'd4);

    // Back-to-back throughput
    fires0 = n_fire;
    tot = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(16'($urandom), 16'($urandom), w);
      tot += w;
    end
    check("b2b_no_stall", {40'h0, 32'(tot)}, 72'h0);
    drain();
    check("b2b_fires", {40'h0, 32'(n_fire - fires0)}, 72'd100);

    // Random in_valid gaps and random out_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        bus.in_a = 16'($urandom);
        bus.in_b = 16'($urandom);
      end
      send(16'($urandom), 16'($urandom), w);
    end
    rand_ready = 1'b0;
    #0;
    drain();

    // Reset with both stages full: nothing from before may emerge
    bus.out_ready = 1'b0;
    send(16'($urandom), 16'($urandom), w);
    send(16'($urandom), 16'($urandom), w);
    check("pre_rst_full", {70'h0, bus.out_valid, bus.in_ready}, 72'h2);
    do_reset();
    fires0 = n_fire;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_no_output", {40'h0, 32'(n_fire - fires0)}, 72'h0);
    send(16'hBEEF, 16'h0102, w);
    drain();
    check("post_rst_op_count", {56'h0, bus.op_count}, 72'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vedic_pp_stage_16.md
Name: vedic_pp_stage_16

Overview:
Upstream feeder for the 16-bit carry-save stage of the 16x16 Vedic multiplier.
- Accepts a 16x16 operand pair and forms the four 8x8 vertical/crosswise partial products.
- Presents the three aligned CSA operands plus the pass-through product bits.
- Two-stage registered pipeline with valid/ready backpressure, so the CSA + ripple stage and the downstream final adder can be retimed independently.

Parameters:
CNT_W, 16, width of the accepted-operation counter (wraps).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept operands this cycle
in_a  in  16  multiplicand
in_b  in  16  multiplier
out_valid  out  1  CSA operand set valid
out_ready  in  1  downstream CSA stage consumes this cycle
csa_a  out  16  AH*BL (q1)
csa_b  out  16  AL*BH (q2)
csa_c  out  16  {8'h00, q0[15:8]}
p_lo  out  8  q0[7:0], final product bits [7:0]
p_hh  out  16  AH*BH (q3), added at bit 16 downstream
op_count  out  CNT_W  number of accepted operations, modulo 2^CNT_W

Behaviour:
- Split operands: AL=in_a[7:0], AH=in_a[15:8], BL=in_b[7:0], BH=in_b[15:8].
- q0=AL*BL, q1=AH*BL, q2=AL*BH, q3=AH*BH. Each is a full 16-bit unsigned product built from 8x8 Vedic multipliers; no truncation.
- Invariant: product = {p_hh,16'h0} + ({csa_a}+{csa_b}+{csa_c})<<8 + p_lo.

Stage S1 (operand register):
- Holds a,b and v1.
- Accept when in_valid && in_ready.

Stage S2 (product register):
- Holds q0..q3 and v2.
- Drives the outputs directly from registers; no combinational path from in_* to out_*.

Handshake:
- out_valid = v2.
- S2 loads when !v2 || out_ready.
- in_ready = !v1 || (S2 loads). Combinational from out_ready, with no path from in_valid.
- Bubble collapsing: an empty stage never blocks the stage behind it.
- Latency: 2 cycles from accept to out_valid with no stall.
- Throughput: one operation per cycle while out_ready=1.

Stall and hold rules:
- While out_valid && !out_ready, all out_* signals hold stable.
- With both stages full under stall, in_ready=0.
- Simultaneous S2 drain and S1 refill in the same cycle are both taken; no operation is lost or duplicated.
- S1 to S2 transfer and a new S1 accept in the same cycle are both allowed.
- Data is presented in accept order.

op_count:
- Increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.

Reset:
- Takes effect on the clock edge with rst=1, including mid-operation; in-flight operations are discarded.
- Resets v1, v2, op_count, csa_a/b/c, p_lo and p_hh to 0.
- out_valid=0. in_ready=1 in the first cycle after reset.
- in_valid is ignored while rst=1.

Out-of-band inputs:
- X/garbage on in_a/in_b while in_valid=0 must not reach the outputs.

Test Plan:
- Basic path: in_a=16'h1234, in_b=16'h5678, out_ready=1 -> 2 cycles later out_valid=1, csa_a=16'h0870, csa_b=16'h1178, csa_c=16'h0018, p_lo=8'h60, p_hh=16'h060C. Reconstructed product = 32'h06260060.
- Max operands: in_a=in_b=16'hFFFF -> csa_a=csa_b=16'hFE01, csa_c=16'h00FE, p_lo=8'h01, p_hh=16'hFE01. Reconstructed product = 32'hFFFE0001.
- Backpressure: stream 4 ops, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts and outputs stay stable. Release -> all 4 results emerge in order with no loss or duplication, and op_count=4.
- Back-to-back throughput: 100 random ops, out_ready=1 -> one result per cycle, each matching a*b via the invariant.
- Random stalls: 1000 random ops with random in_valid/out_ready -> scoreboard matches in order, and stability holds whenever out_valid && !out_ready.
- Reset mid-operation: assert rst with both stages full -> next cycle out_valid=0, all outputs 0, op_count=0, in_ready=1. Nothing from before the reset ever appears.
